// File: rtl/koto_ofc_pkg.sv
// Shared definitions for the KOTO OFC header path: marker defaults, field widths and parser state encoding.
package koto_ofc_pkg;

    localparam logic [5:0] HDR_MARK_DEF = 6'h2A;
    localparam logic [7:0] TRL_MARK_DEF = 8'h5A;
    localparam int         SPILLNO_W    = 10;
    localparam int         EVTNO_W      = 16;
    localparam int         WORD_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVT     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAIL   = 2'd3
    } parser_state_t;

endpackage

// File: rtl/package_header_parser_if.sv
// Stream bundle between the ADC word source and the header parser, including parsed package results.
interface package_header_parser_if;
    import koto_ofc_pkg::*;

    logic [WORD_W-1:0]    din;
    logic                 din_valid;
    logic [SPILLNO_W-1:0] pkg_spillno;
    logic [EVTNO_W-1:0]   pkg_evtno;
    logic                 get_package;
    logic [WORD_W-1:0]    dout;
    logic                 dout_valid;
    logic                 frame_err;
    logic [15:0]          drop_counter;

    modport master (
        output din, din_valid,
        input  pkg_spillno, pkg_evtno, get_package, dout, dout_valid, frame_err, drop_counter
    );

    modport slave (
        input  din, din_valid,
        output pkg_spillno, pkg_evtno, get_package, dout, dout_valid, frame_err, drop_counter
    );

endinterface

// File: rtl/pkg_xor8_acc.sv
// Running 8-bit XOR accumulator used for the package trailer checksum.
module pkg_xor8_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] acc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= 8'h00;
        end else if (clear) begin
            acc <= 8'h00;
        end else if (enable) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/package_header_parser.sv
// Parses ADC package frames (header, event word, NSAMPLE payload words, trailer) and reports spill/event numbers.
// Define PKG_CHECKSUM_EN to also require the trailer low byte to match the XOR of all payload bytes.
module package_header_parser
    import koto_ofc_pkg::*;
#(
    parameter int         NSAMPLE  = 64,
    parameter logic [5:0] HDR_MARK = HDR_MARK_DEF,
    parameter logic [7:0] TRL_MARK = TRL_MARK_DEF
) (
    input logic clk,
    input logic reset,
    package_header_parser_if.slave bus
);

    localparam int               CNT_W = $clog2(NSAMPLE + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSAMPLE - 1);

    parser_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             trl_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef PKG_CHECKSUM_EN
    logic [7:0] xor_acc;

    pkg_xor8_acc u_xor (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.din_valid && state == ST_EVT),
        .enable (bus.din_valid && state == ST_PAYLOAD),
        .data   (bus.din[15:8] ^ bus.din[7:0]),
        .acc    (xor_acc)
    );

    assign trl_ok = (bus.din[15:8] == TRL_MARK) && (bus.din[7:0] == xor_acc);
`else
    assign trl_ok = (bus.din[15:8] == TRL_MARK);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bus.pkg_spillno  <= '0;
            bus.pkg_evtno    <= '0;
            bus.get_package  <= 1'b0;
            bus.dout         <= '0;
            bus.dout_valid   <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.drop_counter <= '0;
        end else begin
            bus.get_package <= 1'b0;
            bus.dout_valid  <= 1'b0;
            bus.frame_err   <= 1'b0;
            if (bus.frame_err) begin
                bus.drop_counter <= sat_inc(bus.drop_counter);
            end
            if (bus.din_valid) begin
                case (state)
                    ST_IDLE: begin
                        // Non-header words here are inter-package fill and are dropped quietly.
                        if (bus.din[15:10] == HDR_MARK) begin
                            bus.pkg_spillno <= bus.din[SPILLNO_W-1:0];
                            state           <= ST_EVT;
                        end
                    end
                    ST_EVT: begin
                        bus.pkg_evtno <= bus.din;
                        cnt           <= '0;
                        state         <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        bus.dout       <= bus.din;
                        bus.dout_valid <= 1'b1;
                        cnt            <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state <= ST_TRAIL;
                        end
                    end
                    ST_TRAIL: begin
                        // A header arriving here is a broken trailer; the package is lost, not restarted.
                        if (trl_ok) begin
                            bus.get_package <= 1'b1;
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_package_header_parser.sv
// Scoreboard bench for package_header_parser with NSAMPLE=4: driver queues expected outputs, monitor checks them.
module tb_package_header_parser;

    localparam int K_DOUT = 0;
    localparam int K_GET  = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [9:0]  spill;
        logic [15:0] evt;
    } exp_t;

    logic clk;
    logic reset;
    package_header_parser_if bus();

    package_header_parser #(.NSAMPLE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        q[$];
    int          total  = 0;
    int          passed = 0;
    logic [15:0] exp_drop = 16'd0;
    bit          drop_pend = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push(input int kind, input logic [15:0] data, input logic [9:0] spill, input logic [15:0] evt);
        exp_t e;
        e.kind = kind; e.data = data; e.spill = spill; e.evt = evt;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        chk("unexpected_output", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("output_kind", 32'(kind), 32'(e.kind));
            if (kind == K_DOUT && e.kind == K_DOUT) chk("dout", 32'(bus.dout), 32'(e.data));
            if (kind == K_GET && e.kind == K_GET) begin
                chk("pkg_spillno", 32'(bus.pkg_spillno), 32'(e.spill));
                chk("pkg_evtno", 32'(bus.pkg_evtno), 32'(e.evt));
            end
        end
    endtask

    // Monitor: every output event is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (reset) begin
            exp_drop  = 16'd0;
            drop_pend = 1'b0;
        end else begin
            if (drop_pend) begin
                chk("drop_counter_incr", 32'(bus.drop_counter), 32'(exp_drop));
                drop_pend = 1'b0;
            end
            if (bus.get_package && bus.frame_err) chk("get_and_err_together", 32'd1, 32'd0);
            if (bus.dout_valid) pop_check(K_DOUT);
            if (bus.get_package) pop_check(K_GET);
            if (bus.frame_err) begin
                pop_check(K_ERR);
                chk("drop_counter_before", 32'(bus.drop_counter), 32'(exp_drop));
                exp_drop  = exp_drop + 16'd1;
                drop_pend = 1'b1;
            end
        end
    end

    task automatic put(input logic [15:0] w, input bit stall);
        @(negedge clk);
        bus.din       = w;
        bus.din_valid = 1'b1;
        if (stall) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.din       = 16'hFFFF;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
        end
    endtask

    task automatic send_pkg(input logic [9:0] spill, input logic [15:0] evt, input logic [63:0] pl,
                            input logic [15:0] trailer, input bit stall, input bit good);
        logic [15:0] w;
        put({6'h2A, spill}, stall);
        put(evt, stall);
        for (int i = 0; i < 4; i++) begin
            w = pl[63-16*i -: 16];
            push(K_DOUT, w, 10'd0, 16'd0);
            put(w, stall);
        end
        if (good) push(K_GET, 16'd0, spill, evt);
        else push(K_ERR, 16'd0, 10'd0, 16'd0);
        put(trailer, stall);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_spillno"}, 32'(bus.pkg_spillno), 32'd0);
        chk({tag, "_evtno"}, 32'(bus.pkg_evtno), 32'd0);
        chk({tag, "_get_package"}, 32'(bus.get_package), 32'd0);
        chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
        chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
        chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        chk({tag, "_drop_counter"}, 32'(bus.drop_counter), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din       = 16'h0000;
        bus.din_valid = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Basic package: spill 3, evt 1, xor of payload bytes = 04.
        send_pkg(10'd3, 16'h0001, 64'h0102_0304_0000_0000, 16'h5A04, 1'b0, 1'b1);
        idle(3);
        // Same package with din_valid toggling.
        send_pkg(10'd3, 16'h0001, 64'h0102_0304_0000_0000, 16'h5A04, 1'b1, 1'b1);
        idle(3);
        // Bad trailer marker.
        send_pkg(10'd4, 16'h0007, 64'h0102_0304_0000_0000, 16'h5B00, 1'b0, 1'b0);
        idle(3);
        // Good package afterwards; payload bytes cancel pairwise.
        send_pkg(10'd5, 16'h0002, 64'h1111_2222_3333_4444, 16'h5A00, 1'b0, 1'b1);
        idle(3);
        // Wrong checksum byte: only rejected when the checksum is built in.
`ifdef PKG_CHECKSUM_EN
        send_pkg(10'd6, 16'h0003, 64'h0102_0304_0000_0000, 16'h5A05, 1'b0, 1'b0);
`else
        send_pkg(10'd6, 16'h0003, 64'h0102_0304_0000_0000, 16'h5A05, 1'b0, 1'b1);
`endif
        idle(3);
        // Header word in trailer slot is a framing error and is not re-parsed.
        send_pkg(10'd7, 16'h0004, 64'h0102_0304_0000_0000, 16'hA807, 1'b0, 1'b0);
        put(16'h0005, 1'b0);
        idle(3);

        // Asynchronous reset while payload word 2 is on the bus.
        put(16'hA803, 1'b0);
        put(16'h0001, 1'b0);
        push(K_DOUT, 16'h0102, 10'd0, 16'd0);
        put(16'h0102, 1'b0);
        @(negedge clk);
        bus.din = 16'h0304;
        #1 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        bus.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_pkg(10'd9, 16'h1234, 64'h0102_0304_0000_0000, 16'h5A04, 1'b0, 1'b1);

        // Idle fill then back-to-back packages; second carries a header-like payload word (A8^09 = A1).
        for (int i = 0; i < 10; i++) put(16'h0000, 1'b0);
        send_pkg(10'd3, 16'h0001, 64'h0102_0304_0000_0000, 16'h5A04, 1'b0, 1'b1);
        send_pkg(10'd3, 16'h0002, 64'hA809_0000_0000_0000, 16'h5AA1, 1'b0, 1'b1);
        idle(6);

        chk("pending_expectations", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
